// File: rtl/cdb_pkg.sv
// Shared types and widths for the common-data-bus writeback arbiter.
package cdb_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ROB_ID_WIDTH   = 5;
  localparam int unsigned PHY_REG_WIDTH  = 6;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0]  rob_id;
    logic [PHY_REG_WIDTH-1:0] phy_reg;
    logic [DATA_WIDTH-1:0]    data;
  } cdb_entry_t;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_MEM = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: circular buffer with occupancy count and squash.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter: ALU and load queues feed one registered CDB slot.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ROB_ID_WIDTH-1:0]  alu_rob_id,
  input  logic [PHY_REG_WIDTH-1:0] alu_phy_reg,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ROB_ID_WIDTH-1:0]  mem_rob_id,
  input  logic [PHY_REG_WIDTH-1:0] mem_phy_reg,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     cdb_valid,
  output logic                     cdb_src,
  output logic [ROB_ID_WIDTH-1:0]  cdb_rob_id,
  output logic [PHY_REG_WIDTH-1:0] cdb_phy_reg,
  output logic [DATA_WIDTH-1:0]    cdb_data,
  output logic [CNT_WIDTH-1:0]     conflict_cnt
);

  cdb_entry_t alu_head, mem_head;
  logic       alu_empty, alu_full, mem_empty, mem_full;
  logic       alu_push_c, mem_push_c;
  logic       grant_alu_c, grant_mem_c, both_c;

  cdb_src_e             last_grant_q, last_grant_d;
  logic                 cdb_valid_q, cdb_valid_d;
  cdb_src_e             cdb_src_q, cdb_src_d;
  cdb_entry_t           cdb_entry_q, cdb_entry_d;
  logic [CNT_WIDTH-1:0] conflict_q, conflict_d;

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign alu_ready  = !alu_full;
  assign mem_ready  = !mem_full;
  assign alu_push_c = alu_valid && alu_ready && !flush;
  assign mem_push_c = mem_valid && mem_ready && !flush;

  cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push_c),
    .pop   (grant_alu_c),
    .din   ({alu_rob_id, alu_phy_reg, alu_data}),
    .dout  (alu_head),
    .empty (alu_empty),
    .full  (alu_full)
  );

  cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (mem_push_c),
    .pop   (grant_mem_c),
    .din   ({mem_rob_id, mem_phy_reg, mem_data}),
    .dout  (mem_head),
    .empty (mem_empty),
    .full  (mem_full)
  );

  assign both_c = !alu_empty && !mem_empty;

  // Grant selection; last_grant only moves when a tie is resolved.
  always_comb begin
    grant_alu_c  = 1'b0;
    grant_mem_c  = 1'b0;
    last_grant_d = last_grant_q;
    if (!flush) begin
      if (both_c) begin
        if (last_grant_q == CDB_SRC_MEM) begin
          grant_alu_c  = 1'b1;
          last_grant_d = CDB_SRC_ALU;
        end else begin
          grant_mem_c  = 1'b1;
          last_grant_d = CDB_SRC_MEM;
        end
      end else if (!alu_empty) begin
        grant_alu_c = 1'b1;
      end else if (!mem_empty) begin
        grant_mem_c = 1'b1;
      end
    end
  end

  // CDB broadcast register and saturating conflict counter.
  always_comb begin
    cdb_valid_d = grant_alu_c || grant_mem_c;
    cdb_src_d   = cdb_src_q;
    cdb_entry_d = cdb_entry_q;
    conflict_d  = conflict_q;
    if (grant_alu_c) begin
      cdb_src_d   = CDB_SRC_ALU;
      cdb_entry_d = alu_head;
    end else if (grant_mem_c) begin
      cdb_src_d   = CDB_SRC_MEM;
      cdb_entry_d = mem_head;
    end
    if (both_c && !flush && (conflict_q != '1)) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= CDB_SRC_MEM;
      cdb_valid_q  <= 1'b0;
      cdb_src_q    <= CDB_SRC_ALU;
      cdb_entry_q  <= '0;
      conflict_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_src_q    <= cdb_src_d;
      cdb_entry_q  <= cdb_entry_d;
      conflict_q   <= conflict_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_src      = cdb_src_q;
  assign cdb_rob_id   = cdb_entry_q.rob_id;
  assign cdb_phy_reg  = cdb_entry_q.phy_reg;
  assign cdb_data     = cdb_entry_q.data;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model plus directed and random traffic.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned D = DEF_FIFO_DEPTH;
  localparam int unsigned W = ROB_ID_WIDTH + PHY_REG_WIDTH + DATA_WIDTH;

  logic clk, rst, flush;
  logic alu_valid, mem_valid;
  logic [ROB_ID_WIDTH-1:0]  alu_rob_id, mem_rob_id;
  logic [PHY_REG_WIDTH-1:0] alu_phy_reg, mem_phy_reg;
  logic [DATA_WIDTH-1:0]    alu_data, mem_data;

  logic alu_ready, mem_ready, cdb_valid, cdb_src;
  logic [ROB_ID_WIDTH-1:0]  cdb_rob_id;
  logic [PHY_REG_WIDTH-1:0] cdb_phy_reg;
  logic [DATA_WIDTH-1:0]    cdb_data;
  logic [15:0]              conflict_cnt;

  logic s_alu_ready, s_mem_ready, s_cdb_valid, s_cdb_src;
  logic [ROB_ID_WIDTH-1:0]  s_cdb_rob_id;
  logic [PHY_REG_WIDTH-1:0] s_cdb_phy_reg;
  logic [DATA_WIDTH-1:0]    s_cdb_data;
  logic [1:0]               s_conflict_cnt;

  cdb_arbiter u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
    .alu_phy_reg(alu_phy_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rob_id(mem_rob_id),
    .mem_phy_reg(mem_phy_reg), .mem_data(mem_data),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_id(cdb_rob_id),
    .cdb_phy_reg(cdb_phy_reg), .cdb_data(cdb_data), .conflict_cnt(conflict_cnt)
  );

  cdb_arbiter #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_rob_id(alu_rob_id),
    .alu_phy_reg(alu_phy_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(s_mem_ready), .mem_rob_id(mem_rob_id),
    .mem_phy_reg(mem_phy_reg), .mem_data(mem_data),
    .cdb_valid(s_cdb_valid), .cdb_src(s_cdb_src), .cdb_rob_id(s_cdb_rob_id),
    .cdb_phy_reg(s_cdb_phy_reg), .cdb_data(s_cdb_data), .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state.
  logic [W-1:0] aq[$];
  logic [W-1:0] mq[$];
  bit           m_last;
  bit           m_valid, m_src;
  logic [W-1:0] m_pay;
  longint       m_conf;

  // Stimulus for the next edge and producer state.
  bit           n_rst, n_flush, n_av, n_mv;
  logic [W-1:0] n_ae, n_me;
  bit           acc_a, acc_m, started;
  bit           pa_v, pm_v;
  logic [W-1:0] pa_e, pm_e;
  logic [ROB_ID_WIDTH-1:0] tag_a, tag_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int rob, input int phy, input logic [31:0] dat);
    logic [ROB_ID_WIDTH-1:0]  r;
    logic [PHY_REG_WIDTH-1:0] p;
    r = ROB_ID_WIDTH'(rob);
    p = PHY_REG_WIDTH'(phy);
    return {r, p, dat};
  endfunction

  task automatic compare_all();
    logic [63:0] c16, c2;
    c16 = (m_conf > 65535) ? 64'd65535 : 64'(m_conf);
    c2  = (m_conf > 3) ? 64'd3 : 64'(m_conf);
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_src", 64'(cdb_src), 64'(m_src));
    chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_pay[W-1 -: ROB_ID_WIDTH]));
    chk("cdb_phy_reg", 64'(cdb_phy_reg), 64'(m_pay[DATA_WIDTH +: PHY_REG_WIDTH]));
    chk("cdb_data", 64'(cdb_data), 64'(m_pay[DATA_WIDTH-1:0]));
    chk("alu_ready", 64'(alu_ready), 64'(aq.size() < D));
    chk("mem_ready", 64'(mem_ready), 64'(mq.size() < D));
    chk("conflict_cnt", 64'(conflict_cnt), c16);
    chk("sat_cdb", 64'({s_cdb_valid, s_cdb_src, s_cdb_rob_id}),
        64'({m_valid, m_src, m_pay[W-1 -: ROB_ID_WIDTH]}));
    chk("sat_ready", 64'({s_alu_ready, s_mem_ready}), 64'({aq.size() < D, mq.size() < D}));
    chk("sat_conflict_cnt", 64'(s_conflict_cnt), c2);
  endtask

  // Apply what one rising edge does to the model, given the inputs for that edge.
  task automatic model_step();
    bit both, ga, gm;
    acc_a = 1'b0;
    acc_m = 1'b0;
    if (n_rst) begin
      aq.delete(); mq.delete();
      m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0; m_pay = '0; m_conf = 0;
    end else if (n_flush) begin
      aq.delete(); mq.delete();
      m_valid = 1'b0;
    end else begin
      acc_a = n_av && (aq.size() < D);
      acc_m = n_mv && (mq.size() < D);
      both  = (aq.size() != 0) && (mq.size() != 0);
      ga = 1'b0; gm = 1'b0;
      if (both) begin
        if (m_last) begin ga = 1'b1; m_last = 1'b0; end
        else        begin gm = 1'b1; m_last = 1'b1; end
      end else if (aq.size() != 0) ga = 1'b1;
      else if (mq.size() != 0) gm = 1'b1;
      m_valid = ga || gm;
      if (ga) begin m_src = 1'b0; m_pay = aq.pop_front(); end
      if (gm) begin m_src = 1'b1; m_pay = mq.pop_front(); end
      if (both) m_conf++;
      if (acc_a) aq.push_back(n_ae);
      if (acc_m) mq.push_back(n_me);
    end
  endtask

  task automatic do_cycle();
    @(negedge clk);
    if (started) compare_all();
    started   = 1'b1;
    rst       = n_rst;
    flush     = n_flush;
    alu_valid = n_av;
    mem_valid = n_mv;
    {alu_rob_id, alu_phy_reg, alu_data} = n_ae;
    {mem_rob_id, mem_phy_reg, mem_data} = n_me;
    model_step();
    if (acc_a || n_rst || n_flush) pa_v = 1'b0;
    if (acc_m || n_rst || n_flush) pm_v = 1'b0;
  endtask

  task automatic idle();
    n_rst = 1'b0; n_flush = 1'b0; n_av = 1'b0; n_mv = 1'b0;
  endtask

  // Producers hold an offered result until it is accepted.
  task automatic produce(input int pa, input int pm);
    if (!pa_v && ($urandom_range(0, 99) < pa)) begin
      pa_v = 1'b1;
      pa_e = {tag_a, PHY_REG_WIDTH'($urandom), 32'($urandom)};
      tag_a++;
    end
    if (!pm_v && ($urandom_range(0, 99) < pm)) begin
      pm_v = 1'b1;
      pm_e = {tag_m, PHY_REG_WIDTH'($urandom), 32'($urandom)};
      tag_m++;
    end
    n_av = pa_v; n_ae = pa_e;
    n_mv = pm_v; n_me = pm_e;
  endtask

  task automatic reset_dut();
    idle(); n_rst = 1'b1;
    do_cycle();
    idle();
  endtask

  initial begin
    bit srcs[$];
    bit seen_full;
    int nvalid;
    rst = 1'b1; flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    {alu_rob_id, alu_phy_reg, alu_data} = '0;
    {mem_rob_id, mem_phy_reg, mem_data} = '0;
    started = 1'b0; pa_v = 1'b0; pm_v = 1'b0; tag_a = '0; tag_m = 5'd16;
    n_ae = '0; n_me = '0; pa_e = '0; pm_e = '0;
    reset_dut();

    // Single ALU result: visible two edges after offer, for one cycle.
    n_av = 1'b1; n_ae = mk(3, 10, 32'hDEAD);
    do_cycle();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_ready", 64'({alu_ready, mem_ready}), 64'd3);
    chk("rst_conflict", 64'(conflict_cnt), 64'd0);
    idle();
    do_cycle();
    chk("t1_early", 64'(cdb_valid), 64'd0);
    do_cycle();
    chk("t1_bcast", 64'({cdb_valid, cdb_src, cdb_rob_id, cdb_phy_reg}), 64'({1'b1, 1'b0, 5'd3, 6'd10}));
    chk("t1_data", 64'(cdb_data), 64'h0000_DEAD);
    do_cycle();
    chk("t1_once", 64'(cdb_valid), 64'd0);

    // Simultaneous ALU/MEM: ALU first on the first tie.
    reset_dut();
    n_av = 1'b1; n_ae = mk(1, 1, 32'h11);
    n_mv = 1'b1; n_me = mk(2, 2, 32'h22);
    do_cycle();
    idle();
    do_cycle();
    do_cycle();
    chk("t2_first", 64'({cdb_valid, cdb_src, cdb_rob_id}), 64'({1'b1, 1'b0, 5'd1}));
    chk("t2_conflict", 64'(conflict_cnt), 64'd1);
    do_cycle();
    chk("t2_second", 64'({cdb_valid, cdb_src, cdb_rob_id}), 64'({1'b1, 1'b1, 5'd2}));
    chk("t2_conflict_hold", 64'(conflict_cnt), 64'd1);

    // Both saturated: strict alternation, back-pressure, narrow counter saturates.
    reset_dut();
    seen_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) produce(100, 100); else begin produce(0, 0); n_av = pa_v; n_mv = pm_v; end
      do_cycle();
      if (cdb_valid) srcs.push_back(cdb_src);
      if (!alu_ready) seen_full = 1'b1;
    end
    chk("t3_count", 64'(srcs.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < srcs.size(); i++) chk("t3_alt", 64'(srcs[i]), 64'(i % 2));
    chk("t3_alu_backpressure", 64'(seen_full), 64'd1);
    chk("t6_sat", 64'(s_conflict_cnt), 64'd3);

    // Flush squashes queued and in-flight results.
    reset_dut();
    n_av = 1'b1; n_ae = mk(7, 1, 32'h7); do_cycle();
    n_ae = mk(8, 2, 32'h8); do_cycle();
    n_ae = mk(9, 3, 32'h9); do_cycle();
    n_flush = 1'b1; n_ae = mk(10, 4, 32'hA); do_cycle();
    idle();
    do_cycle();
    do_cycle();
    chk("t4_flush", 64'({cdb_valid, alu_ready}), 64'({1'b0, 1'b1}));
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin do_cycle(); if (cdb_valid) nvalid++; end
    chk("t4_no_ghost", 64'(nvalid), 64'd0);

    // Reset with queues loaded.
    for (int i = 0; i < 5; i++) begin produce(100, 100); do_cycle(); end
    reset_dut();
    do_cycle();
    chk("t5_outputs", 64'({cdb_valid, cdb_src, cdb_rob_id, cdb_phy_reg}), 64'd0);
    chk("t5_data_cnt", 64'({cdb_data, conflict_cnt}), 64'd0);
    chk("t5_ready", 64'({alu_ready, mem_ready}), 64'd3);

    // Randomized traffic with occasional flush and reset.
    for (int blk = 0; blk < 30; blk++) begin
      int pa, pm;
      pa = $urandom_range(0, 100);
      pm = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        idle();
        produce(pa, pm);
        n_flush = ($urandom_range(0, 39) == 0);
        n_rst   = ($urandom_range(0, 199) == 0);
        do_cycle();
      end
    end
    idle();
    do_cycle();
    do_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
